// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//
// APB3 completer exposing NUM_REGS read/write word registers. One instance
// sits behind one bit of the requester's PSEL vector. Every transfer is
// stretched by WAIT_STATES cycles with PREADY low. The register contents are
// exported on regs_o.
//
// Optional feature macro: APB_SLV_PSLVERR_EN
//   defined     -> PSLVERR port exists and flags out-of-range accesses.
//   not defined -> no PSLVERR port. Out-of-range accesses complete silently.
//
// Ports
//   PCLK         in   APB clock. All logic runs on the rising edge.
//   PRESETn      in   asynchronous active-low reset
//   PSEL         in   this slave's select bit
//   PADDR        in   byte address, ADDR_WIDTH bits
//   PWRITE       in   1 = write, 0 = read
//   PENABLE      in   access-phase indicator
//   PWDATA       in   write data, DATA_WIDTH bits
//   PREADY       out  transfer completes on the edge where PSEL & PENABLE & PREADY
//   PRDATA       out  read data. Valid while PREADY = 1 on reads.
//   PSLVERR      out  error response (only with APB_SLV_PSLVERR_EN)
//   regs_o       out  register contents. Reg i is at [i*DATA_WIDTH +: DATA_WIDTH].
//   o_dbg_state  out  current FSM state (0 = IDLE, 1 = ACCESS)
//
// Handshake: a transfer is a setup edge (PSEL=1, PENABLE=0) that is seen in
// IDLE, followed by access cycles (PSEL=1, PENABLE=1). The transfer completes
// on the first edge where PSEL & PENABLE & PREADY. If PSEL drops at any
// ACCESS edge, the transfer is aborted and has no side effect.
// -----------------------------------------------------------------------------
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = `D_ADDR_WIDTH,
  parameter int DATA_WIDTH  = `D_DATA_WIDTH,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PWRITE,
  input  logic                           PENABLE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
`ifdef APB_SLV_PSLVERR_EN
  output logic                           PSLVERR,
`endif
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [0:0]                     o_dbg_state
);

  localparam int LSB  = $clog2(DATA_WIDTH / 8);
  localparam int IDXW = $clog2(NUM_REGS);
  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_pready;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [IDXW-1:0]       r_idx;
  logic                  r_in_range;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
`ifdef APB_SLV_PSLVERR_EN
  logic                  r_slverr;
`endif

  logic [IDXW-1:0]       w_idx;
  logic [ADDR_WIDTH-1:0] w_addr_hi;
  logic                  w_in_range;
  logic                  w_setup;
  logic                  w_unused_addr;

  // The byte-offset bits are ignored. The address is in range exactly when
  // every bit above the index field is zero, i.e. PADDR < NUM_REGS*bytes.
  assign w_idx         = PADDR[LSB +: IDXW];
  assign w_addr_hi     = PADDR >> (LSB + IDXW);
  assign w_in_range    = (w_addr_hi == '0);
  assign w_setup       = PSEL && !PENABLE;
  assign w_unused_addr = ^PADDR;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pready   <= 1'b0;
      r_prdata   <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_idx      <= '0;
      r_in_range <= 1'b0;
`ifdef APB_SLV_PSLVERR_EN
      r_slverr   <= 1'b0;
`endif
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // PSEL & PENABLE without a preceding setup phase is ignored.
          if (w_setup) begin
            r_state    <= S_ACCESS;
            r_write    <= PWRITE;
            r_wdata    <= PWDATA;
            r_idx      <= w_idx;
            r_in_range <= w_in_range;
            r_cnt      <= WS4;
            r_pready   <= (WS4 == 4'd0);
            // Read data is captured at setup. It therefore sees a write that
            // completed on the previous edge (back-to-back write then read).
            r_prdata   <= (!PWRITE && w_in_range) ? r_regs[w_idx] : '0;
`ifdef APB_SLV_PSLVERR_EN
            r_slverr   <= (WS4 == 4'd0) ? !w_in_range : 1'b0;
`endif
          end
        end
        S_ACCESS: begin
          if (!PSEL) begin
            // Abort: leave without touching the register bank.
            r_state  <= S_IDLE;
            r_pready <= 1'b0;
            r_prdata <= '0;
`ifdef APB_SLV_PSLVERR_EN
            r_slverr <= 1'b0;
`endif
          end else if (!r_pready) begin
            // Count down the wait states. PREADY rises when the count reaches 1.
            r_cnt    <= r_cnt - 4'd1;
            r_pready <= (r_cnt == 4'd1);
`ifdef APB_SLV_PSLVERR_EN
            r_slverr <= (r_cnt == 4'd1) ? !r_in_range : 1'b0;
`endif
          end else if (PENABLE) begin
            if (r_write && r_in_range) begin
              r_regs[r_idx] <= r_wdata;
            end
            r_state  <= S_IDLE;
            r_pready <= 1'b0;
            r_prdata <= '0;
`ifdef APB_SLV_PSLVERR_EN
            r_slverr <= 1'b0;
`endif
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_pready <= 1'b0;
          r_prdata <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign PREADY      = r_pready;
  assign PRDATA      = r_prdata;
  assign o_dbg_state = r_state;
`ifdef APB_SLV_PSLVERR_EN
  assign PSLVERR     = r_slverr;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
//
// Directed bench for apb_slave_regfile. Two instances share one APB bus:
//   u_dut2  WAIT_STATES = 2  (selected by psel2)
//   u_dut0  WAIT_STATES = 0  (selected by psel0)
// Expected values are hand-computed constants. A reference array tracks what
// each register bank should hold.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_apb_slave_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- bus signals
  logic          psel2 = 1'b0;
  logic          psel0 = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;

  logic             pready2, pready0;
  logic [DW-1:0]    prdata2, prdata0;
  logic [NR*DW-1:0] regs2, regs0;
  logic [0:0]       dbg2, dbg0;
`ifdef APB_SLV_PSLVERR_EN
  logic             slverr2, slverr0;
`endif

  apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(2)) u_dut2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel2), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PREADY(pready2), .PRDATA(prdata2),
`ifdef APB_SLV_PSLVERR_EN
    .PSLVERR(slverr2),
`endif
    .regs_o(regs2), .o_dbg_state(dbg2)
  );

  apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PREADY(pready0), .PRDATA(prdata0),
`ifdef APB_SLV_PSLVERR_EN
    .PSLVERR(slverr0),
`endif
    .regs_o(regs0), .o_dbg_state(dbg0)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_regs2 [NR];
  logic [DW-1:0] exp_regs0 [NR];

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [NR*DW-1:0] flat, input int i);
    return flat[i*DW +: DW];
  endfunction

  task automatic check_bank2(input string tag);
    for (int i = 0; i < NR; i++) begin
      check_val($sformatf("%s_w%0d", tag, i), word_of(regs2, i), exp_regs2[i]);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // The caller must start this task #1 after a rising edge. It returns #1
  // after the completing edge, so a following call is back-to-back.
  // During the access phase, address, data and direction are scrambled.
  task automatic apb_xfer(input int sel, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                          output logic err, output int n_low);
    bit got;
    got   = 1'b0;
    n_low = 0;
    rdata = '0;
    err   = 1'b0;
    psel2   = (sel == 2);
    psel0   = (sel == 0);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = $urandom;
    pwdata  = $urandom;
    pwrite  = ~wr;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((sel == 2) ? pready2 : pready0) begin
        got = 1'b1;
        break;
      end
      n_low++;
    end
    check_val("xfer_ready_seen", {31'b0, got}, 32'd1);
    rdata = (sel == 2) ? prdata2 : prdata0;
`ifdef APB_SLV_PSLVERR_EN
    err = (sel == 2) ? slverr2 : slverr0;
`endif
    @(posedge clk); #1;
    psel2   = 1'b0;
    psel0   = 1'b0;
    penable = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [DW-1:0] rd;
  logic          er;
  int            nl;

  initial begin
    for (int i = 0; i < NR; i++) begin
      exp_regs2[i] = '0;
      exp_regs0[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_pready2", {31'b0, pready2}, 32'd0);
    check_val("rst_prdata2", prdata2, 32'd0);
    check_val("rst_state2", {31'b0, dbg2}, 32'd0);
    check_val("rst_pready0", {31'b0, pready0}, 32'd0);
    check_bank2("rst_bank2");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WAIT_STATES=2: write then read word 2
    apb_xfer(2, 1'b1, 32'h08, 32'hDEADBEEF, rd, er, nl);
    exp_regs2[2] = 32'hDEADBEEF;
    check_val("ws2_wr_low_cycles", nl, 32'd2);
    check_val("ws2_wr_word2", word_of(regs2, 2), 32'hDEADBEEF);
    apb_xfer(2, 1'b0, 32'h08, 32'h0, rd, er, nl);
    check_val("ws2_rd_low_cycles", nl, 32'd2);
    check_val("ws2_rd_data", rd, 32'hDEADBEEF);
    check_val("ws2_rd_slverr", {31'b0, er}, 32'd0);

    // Last register, with byte-offset bits set (they are ignored)
    apb_xfer(2, 1'b1, 32'h3E, 32'h12345678, rd, er, nl);
    exp_regs2[15] = 32'h12345678;
    check_val("top_word15", word_of(regs2, 15), 32'h12345678);
    apb_xfer(2, 1'b0, 32'h3C, 32'h0, rd, er, nl);
    check_val("top_rd_data", rd, 32'h12345678);

    // Abort: drop PSEL in the 2nd access cycle of a write to word 3
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hAAAA;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check_val("abort_acc1_pready", {31'b0, pready2}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("abort_acc2_pready", {31'b0, pready2}, 32'd0);
    psel2 = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_val("abort_state_idle", {31'b0, dbg2}, 32'd0);
    check_val("abort_pready", {31'b0, pready2}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("abort_pready_late", {31'b0, pready2}, 32'd0);
    check_val("abort_word3", word_of(regs2, 3), 32'h0);
    @(posedge clk); #1;

    // Out of range: write then read at 0x40
    apb_xfer(2, 1'b1, 32'h40, 32'h5555, rd, er, nl);
    check_val("oor_wr_low_cycles", nl, 32'd2);
`ifdef APB_SLV_PSLVERR_EN
    check_val("oor_wr_slverr", {31'b0, er}, 32'd1);
`endif
    check_bank2("oor_bank2");
    apb_xfer(2, 1'b0, 32'h40, 32'h0, rd, er, nl);
    check_val("oor_rd_data", rd, 32'h0);
`ifdef APB_SLV_PSLVERR_EN
    check_val("oor_rd_slverr", {31'b0, er}, 32'd1);
`endif

    // Stray PENABLE without a setup phase
    psel2 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h08;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val($sformatf("stray_pready_%0d", k), {31'b0, pready2}, 32'd0);
      check_val($sformatf("stray_state_%0d", k), {31'b0, dbg2}, 32'd0);
    end
    @(posedge clk); #1;
    psel2 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    // WAIT_STATES=0: back-to-back writes, then a read
    apb_xfer(0, 1'b1, 32'h00, 32'h1111, rd, er, nl);
    check_val("ws0_wr0_low_cycles", nl, 32'd0);
    apb_xfer(0, 1'b1, 32'h04, 32'h2222, rd, er, nl);
    check_val("ws0_wr1_low_cycles", nl, 32'd0);
    exp_regs0[0] = 32'h1111;
    exp_regs0[1] = 32'h2222;
    check_val("ws0_word0", word_of(regs0, 0), exp_regs0[0]);
    check_val("ws0_word1", word_of(regs0, 1), exp_regs0[1]);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, er, nl);
    check_val("ws0_rd_low_cycles", nl, 32'd0);
    check_val("ws0_rd_data", rd, 32'h2222);
    check_val("ws0_dut2_untouched", word_of(regs2, 0), 32'h0);

    // Asynchronous reset in the middle of a read of word 2
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h08;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (3) @(negedge clk);
    check_val("mid_pready_before_rst", {31'b0, pready2}, 32'd1);
    check_val("mid_prdata_before_rst", prdata2, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_pready", {31'b0, pready2}, 32'd0);
    check_val("mid_rst_prdata", prdata2, 32'h0);
    check_val("mid_rst_state", {31'b0, dbg2}, 32'd0);
    for (int i = 0; i < NR; i++) exp_regs2[i] = '0;
    check_bank2("mid_rst_bank2");
    check_val("mid_rst_word0_dut0", word_of(regs0, 0), 32'h0);
    psel2 = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
